// File: rtl/patron_scroll_pkg.sv
// Shared types and constants for the patrons overlay scroll sequencer.
//   state_t      : sequencer states
//   *_DEF        : default widths for position, step and dwell counter
//   RAMP_PERIOD  : ticks between effective-step increments when the
//                  PATRON_SCROLL_RAMP_EN build option is defined
package patron_scroll_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_HOLD = 3'd1,
        SCROLL     = 3'd2,
        END_HOLD   = 3'd3,
        DONE       = 3'd4
    } state_t;

    localparam int POS_W_DEF   = 12;
    localparam int STEP_W_DEF  = 4;
    localparam int HOLD_W_DEF  = 8;
    localparam int RAMP_PERIOD = 8;

endpackage

// File: rtl/patron_scroll_ctrl_vsync_tick_sync.sv
// Brings the active-low VSync into clk_sys and produces a one-cycle
// registered pulse per falling edge.
//   clk_sys    : system clock
//   reset_n    : asynchronous active-low reset
//   vs_in      : VSync, active low, asynchronous to clk_sys
//   frame_tick : one-cycle pulse, 3 clk_sys edges after vs_in falls
module vsync_tick_sync (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic vs_in,
    output logic frame_tick
);

    logic sync_1;
    logic sync_2;
    logic vs_hist;

    // All history flops reset to the inactive (high) level so that leaving
    // reset with VSync high cannot look like a falling edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            vs_hist    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            sync_1     <= vs_in;
            sync_2     <= sync_1;
            vs_hist    <= sync_2;
            frame_tick <= vs_hist & ~sync_2;
        end
    end

endmodule

// File: rtl/patron_scroll_ctrl.sv
// Frame-rate scroll sequencer for the patrons overlay. Produces the offset
// the renderer adds to the patron text position, with start/end dwell,
// clamping at limit and optional looping.
//
// Build option: PATRON_SCROLL_RAMP_EN -- when defined, the per-frame step
// ramps from 1 up to step, rising by 1 every RAMP_PERIOD ticks.
//
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   vs_in            : VSync (active low, asynchronous)
//   enable           : display request level
//   step             : pixels per frame
//   limit            : end position
//   hold_frames      : dwell length (hold_frames+1 ticks) at start and end
//   loop             : 1 = restart after end dwell, 0 = stop in DONE
//   dir              : 1 = negate the scroll output
//   scroll           : registered offset, one cycle behind pos
//   frame_tick       : one-cycle pulse per VSync falling edge
//   active, done     : registered from the next state
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | overlay off, pos = 0
// START_HOLD | dwell at pos 0 before scrolling
// SCROLL     | pos advances by the effective step each tick
// END_HOLD   | dwell at limit
// DONE       | parked at limit (loop = 0)
module patron_scroll_ctrl
    import patron_scroll_pkg::*;
#(
    parameter int POS_W  = POS_W_DEF,
    parameter int STEP_W = STEP_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              vs_in,
    input  logic              enable,
    input  logic [STEP_W-1:0] step,
    input  logic [POS_W-1:0]  limit,
    input  logic [HOLD_W-1:0] hold_frames,
    input  logic              loop,
    input  logic              dir,
    output logic [POS_W-1:0]  scroll,
    output logic              frame_tick,
    output logic              active,
    output logic              done
);

    state_t             state, state_nx;
    logic [POS_W-1:0]   pos, pos_nx;
    logic [HOLD_W-1:0]  hold_cnt, hold_nx;
    logic [STEP_W-1:0]  eff;
    logic [POS_W:0]     eff_ext;
    logic [POS_W:0]     sum;

    vsync_tick_sync u_tick (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .vs_in      (vs_in),
        .frame_tick (frame_tick)
    );

`ifdef PATRON_SCROLL_RAMP_EN
    logic [2:0]        ramp_cnt, ramp_nx;
    logic [STEP_W-1:0] eff_step, eff_step_nx;

    // Clamp against the live step so a lowered step takes effect at once.
    assign eff = (eff_step < step) ? eff_step : step;
`else
    assign eff = step;
`endif

    assign eff_ext = {{(POS_W + 1 - STEP_W){1'b0}}, eff};
    // One extra bit so pos+step never wraps before the limit compare.
    assign sum     = {1'b0, pos} + eff_ext;

    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        hold_nx  = hold_cnt;
`ifdef PATRON_SCROLL_RAMP_EN
        ramp_nx     = ramp_cnt;
        eff_step_nx = eff_step;
`endif
        if (!enable) begin
            state_nx = IDLE;
            pos_nx   = '0;
            hold_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = START_HOLD;
                    pos_nx   = '0;
                    hold_nx  = '0;
                end
                START_HOLD, END_HOLD: begin
                    if (frame_tick) begin
                        if (hold_cnt == hold_frames) begin
                            hold_nx = '0;
                            if (state == START_HOLD) begin
                                state_nx = SCROLL;
`ifdef PATRON_SCROLL_RAMP_EN
                                ramp_nx     = '0;
                                eff_step_nx = (step == '0) ? '0 : STEP_W'(1);
`endif
                            end else if (loop) begin
                                state_nx = START_HOLD;
                                pos_nx   = '0;
                            end else begin
                                state_nx = DONE;
                            end
                        end else begin
                            hold_nx = hold_cnt + 1'b1;
                        end
                    end
                end
                SCROLL: begin
                    if (frame_tick) begin
                        if (sum >= {1'b0, limit}) begin
                            pos_nx   = limit;
                            state_nx = END_HOLD;
                        end else begin
                            pos_nx = sum[POS_W-1:0];
                        end
`ifdef PATRON_SCROLL_RAMP_EN
                        ramp_nx = ramp_cnt + 1'b1;
                        if (ramp_cnt == 3'(RAMP_PERIOD - 1))
                            eff_step_nx = (eff_step < step) ? eff_step + 1'b1 : step;
`endif
                    end
                end
                DONE: begin
                    state_nx = DONE;
                end
                default: begin
                    state_nx = IDLE;
                    pos_nx   = '0;
                    hold_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pos      <= '0;
            hold_cnt <= '0;
            scroll   <= '0;
            active   <= 1'b0;
            done     <= 1'b0;
`ifdef PATRON_SCROLL_RAMP_EN
            ramp_cnt <= '0;
            eff_step <= '0;
`endif
        end else begin
            state    <= state_nx;
            pos      <= pos_nx;
            hold_cnt <= hold_nx;
            scroll   <= dir ? -pos : pos;
            active   <= (state_nx != IDLE);
            done     <= (state_nx == DONE);
`ifdef PATRON_SCROLL_RAMP_EN
            ramp_cnt <= ramp_nx;
            eff_step <= eff_step_nx;
`endif
        end
    end

endmodule

// File: tb/tb_patron_scroll_ctrl.sv
module tb_patron_scroll_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        vs_in;
    logic        enable;
    logic [3:0]  step;
    logic [11:0] limit;
    logic [7:0]  hold_frames;
    logic        loop;
    logic        dir;
    logic [11:0] scroll;
    logic        frame_tick;
    logic        active;
    logic        done;

    int checks = 0;
    int errors = 0;

    patron_scroll_ctrl dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .vs_in       (vs_in),
        .enable      (enable),
        .step        (step),
        .limit       (limit),
        .hold_frames (hold_frames),
        .loop        (loop),
        .dir         (dir),
        .scroll      (scroll),
        .frame_tick  (frame_tick),
        .active      (active),
        .done        (done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 start dwell, 2 scrolling, 3 end dwell, 4 parked
    int          m_phase, m_pos, m_dwell, m_sticks, m_eff;
    bit          s0, s1, s2, s3;
    bit          m_tick;
    logic [11:0] e_scroll;
    bit          e_active, e_done;

    always @(posedge clk_sys) begin
        if (!reset_n) begin
            m_phase = 0; m_pos = 0; m_dwell = 0; m_sticks = 0;
            s0 = 1; s1 = 1; s2 = 1; s3 = 1;
            m_tick = 0; e_scroll = '0; e_active = 0; e_done = 0;
        end else begin
            e_scroll = dir ? 12'(-m_pos) : 12'(m_pos);
            if (!enable) begin
                m_phase = 0; m_pos = 0; m_dwell = 0;
            end else begin
                case (m_phase)
                    0: begin m_phase = 1; m_pos = 0; m_dwell = 0; end
                    1, 3: if (m_tick) begin
                        m_dwell++;
                        if (m_dwell == int'(hold_frames) + 1) begin
                            m_dwell = 0;
                            if (m_phase == 1) begin
                                m_phase = 2; m_sticks = 0;
                            end else if (loop) begin
                                m_phase = 1; m_pos = 0;
                            end else begin
                                m_phase = 4;
                            end
                        end
                    end
                    2: if (m_tick) begin
`ifdef PATRON_SCROLL_RAMP_EN
                        m_eff = 1 + m_sticks / 8;
                        if (m_eff > int'(step)) m_eff = int'(step);
`else
                        m_eff = int'(step);
`endif
                        m_sticks++;
                        if (m_pos + m_eff >= int'(limit)) begin
                            m_pos = int'(limit); m_phase = 3; m_dwell = 0;
                        end else begin
                            m_pos = m_pos + m_eff;
                        end
                    end
                    default: ;
                endcase
            end
            e_active = (m_phase != 0);
            e_done   = (m_phase == 4);
            // falling edge seen two samples ago, after a high sample before it
            s3 = s2; s2 = s1; s1 = s0; s0 = vs_in;
            m_tick = !s2 && s3;
        end
    end

    always @(negedge clk_sys) begin
        if (reset_n) begin
            chk("scroll", 32'(scroll), 32'(e_scroll));
            chk("frame_tick", 32'(frame_tick), 32'(m_tick));
            chk("active", 32'(active), 32'(e_active));
            chk("done", 32'(done), 32'(e_done));
        end
    end

    // ---------------- stimulus ----------------
    // One VSync low pulse; on return the outputs reflect the resulting tick.
    task automatic pulse();
        @(negedge clk_sys); vs_in = 1'b0;
        repeat (4) @(negedge clk_sys);
        vs_in = 1'b1;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    task automatic drop_enable();
        @(negedge clk_sys); enable = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("disabled_active", 32'(active), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; vs_in = 1; enable = 0; step = 4; limit = 20;
        hold_frames = 2; loop = 0; dir = 0;
        repeat (3) @(negedge clk_sys);
        chk("rst_scroll", 32'(scroll), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_done", 32'(done), 0);
        #3 reset_n = 1;

        // run to DONE, no loop
        @(negedge clk_sys); enable = 1;
        pulses(3);
        chk("s1_hold_scroll", 32'(scroll), 0);
        chk("s1_hold_active", 32'(active), 1);
`ifndef PATRON_SCROLL_RAMP_EN
        pulse();
        chk("s1_first_step", 32'(scroll), 4);
        pulses(4);
        chk("s1_at_limit", 32'(scroll), 20);
        pulses(3);
        chk("s1_done", 32'(done), 1);
        pulse();
        chk("s1_done_scroll", 32'(scroll), 20);
`else
        pulses(9);
`endif
        drop_enable();

        // loop with negated output
        loop = 1; dir = 1; @(negedge clk_sys); enable = 1;
        pulses(4);
`ifndef PATRON_SCROLL_RAMP_EN
        chk("s2_neg4", 32'(scroll), 32'h0FFC);
        pulses(4);
        chk("s2_neg20", 32'(scroll), 32'h0FEC);
        pulses(3);
        chk("s2_wrapped", 32'(scroll), 0);
        chk("s2_no_done", 32'(done), 0);
        pulses(3);
`else
        pulses(10);
`endif
        drop_enable();

        // clamp at a limit that is not a step multiple
        loop = 0; dir = 0; limit = 10; step = 3; hold_frames = 0;
        @(negedge clk_sys); enable = 1;
        pulses(5);
`ifndef PATRON_SCROLL_RAMP_EN
        chk("s3_clamped", 32'(scroll), 10);
        pulse();
        chk("s3_done", 32'(done), 1);
`else
        pulse();
`endif
        drop_enable();

        // zero limit: first scroll tick ends the scroll
        limit = 0; @(negedge clk_sys); enable = 1;
        pulses(3);
        chk("s3_zero_done", 32'(done), 1);
        chk("s3_zero_scroll", 32'(scroll), 0);
        drop_enable();

        // enable dropped on the tick cycle
        limit = 20; step = 4; @(negedge clk_sys); enable = 1;
        pulses(3);
`ifndef PATRON_SCROLL_RAMP_EN
        chk("s4_pos8", 32'(scroll), 8);
`endif
        @(negedge clk_sys); vs_in = 0;
        repeat (3) @(negedge clk_sys);
        chk("s4_tick_high", 32'(frame_tick), 1);
        enable = 0;
        @(negedge clk_sys);
        chk("s4_idle_active", 32'(active), 0);
        chk("s4_tick_low", 32'(frame_tick), 0);
        @(negedge clk_sys);
        chk("s4_scroll_zero", 32'(scroll), 0);
        vs_in = 1;
        repeat (4) @(negedge clk_sys);

        // reset in the middle of a scroll
        limit = 37; enable = 1;
        pulses(8);
        #2 reset_n = 0;
        #1;
        chk("r_scroll", 32'(scroll), 0);
        chk("r_active", 32'(active), 0);
        chk("r_tick", 32'(frame_tick), 0);
        enable = 0;
        repeat (2) @(negedge clk_sys);
        #3 reset_n = 1;
        repeat (4) @(negedge clk_sys);
        chk("r_no_tick", 32'(frame_tick), 0);

        // step ramp (or full step from the first tick)
        step = 3; limit = 4095; hold_frames = 0;
        @(negedge clk_sys); enable = 1;
        pulses(9);
`ifdef PATRON_SCROLL_RAMP_EN
        chk("ramp_8", 32'(scroll), 8);
        pulses(8);
        chk("ramp_16", 32'(scroll), 24);
        pulse();
        chk("ramp_17", 32'(scroll), 27);
        dir = 1; repeat (2) @(negedge clk_sys);
        chk("ramp_neg", 32'(scroll), 32'h0FE5);
`else
        chk("flat_8", 32'(scroll), 24);
        pulses(8);
        chk("flat_16", 32'(scroll), 48);
        pulse();
        chk("flat_17", 32'(scroll), 51);
        dir = 1; repeat (2) @(negedge clk_sys);
        chk("flat_neg", 32'(scroll), 32'h0FCD);
`endif
        drop_enable();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
